// File: rtl/f1_pkg.sv
// Shared types and constants for the race-start sequencer.
//   state_t     : sequencer states
//   LIGHTS_ALL  : light-strip pattern with every light on
//   REACT_SAT   : saturation value of the reaction counter
//   lfsr8_next  : one step of the 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LIGHTS = 3'd1,
    HOLD   = 3'd2,
    REACT  = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [7:0]  LIGHTS_ALL = 8'hFF;
  localparam logic [15:0] REACT_SAT  = 16'hFFFF;

  // Shift left, feed back the XOR of the tap bits 8,6,5,4 (q[7],q[5],q[4],q[3]).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Signal bundle between the start sequencer and its surroundings
// (driver inputs, tick divider, light strip and result outputs).
//   master : the sequencer side (consumes trigger/react/tick, drives the rest)
//   slave  : the environment side (drives trigger/react/tick)
interface f1_start_ctrl_if;

  logic        trigger;
  logic        react;
  logic        tick;
  logic        tick_en;
  logic [15:0] tick_n;
  logic [7:0]  data_out;
  logic [15:0] react_time;
  logic        result_valid;
  logic        false_start;

  modport master (
    input  trigger, react, tick,
    output tick_en, tick_n, data_out, react_time, result_valid, false_start
  );

  modport slave (
    output trigger, react, tick,
    input  tick_en, tick_n, data_out, react_time, result_valid, false_start
  );

endinterface

// File: rtl/f1_start_ctrl_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the random all-lights hold time.
//   clk : system clock
//   rst : asynchronous active-low reset, loads SEED
//   q   : current LFSR value, advances every clock
module lfsr8
  import f1_pkg::*;
#(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  // LFSR state register, one step per clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= SEED;
    end else begin
      q <= lfsr8_next(q);
    end
  end

endmodule

// File: rtl/f1_start_ctrl.sv
// Race-start sequencer. Steps 8 lights on one per tick, holds them for a
// pseudo-random number of ticks, blanks them, then times the driver's press.
// An early press (lights still on) flags a false start.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : master side of f1_start_ctrl_if (trigger/react/tick in;
//          tick_en/tick_n/data_out/react_time/result_valid/false_start out)
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter logic [15:0] N_LIGHT   = 16'd47999,
  parameter logic [15:0] N_REACT   = 16'd47,
  parameter logic [7:0]  LFSR_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  f1_start_ctrl_if.master  bus
);

  state_t      state_r, state_s;
  logic [7:0]  data_r, data_s;
  logic        tick_en_r, tick_en_s;
  logic [15:0] tick_n_r, tick_n_s;
  logic [15:0] react_time_r, react_time_s;
  logic        result_valid_r, result_valid_s;
  logic        false_start_r, false_start_s;
  logic [7:0]  hold_cnt_r, hold_cnt_s;
  logic [15:0] react_cnt_r, react_cnt_s;
  logic        trigger_q_r, react_q_r;
  logic        trig_re_s, react_re_s;
  logic [7:0]  lfsr_q_s;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q_s)
  );

  assign trig_re_s  = bus.trigger & ~trigger_q_r;
  assign react_re_s = bus.react   & ~react_q_r;

  // One-cycle delay registers for the rising-edge detectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trigger_q_r <= 1'b0;
      react_q_r   <= 1'b0;
    end else begin
      trigger_q_r <= bus.trigger;
      react_q_r   <= bus.react;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output logic; a press always wins over a same-cycle tick.
  always_comb begin
    state_s        = state_r;
    data_s         = data_r;
    tick_en_s      = tick_en_r;
    tick_n_s       = tick_n_r;
    react_time_s   = react_time_r;
    result_valid_s = 1'b0;
    false_start_s  = false_start_r;
    hold_cnt_s     = hold_cnt_r;
    react_cnt_s    = react_cnt_r;

    case (state_r)
      IDLE, DONE, FAULT: begin
        tick_en_s = 1'b0;
        data_s    = 8'h00;
        if (trig_re_s) begin
          state_s       = LIGHTS;
          false_start_s = 1'b0;
          tick_n_s      = N_LIGHT;
          tick_en_s     = 1'b1;
        end else begin
          state_s = state_r;
        end
      end

      LIGHTS: begin
        if (react_re_s) begin
          false_start_s = 1'b1;
          tick_en_s     = 1'b0;
          data_s        = 8'h00;
          state_s       = FAULT;
        end else if (bus.tick) begin
          data_s = {data_r[6:0], 1'b1};
          if (data_r == LIGHTS_ALL) begin
            // Masking bit 7 gives a hold of 1..128 ticks.
            hold_cnt_s = (lfsr_q_s & 8'h7F) + 8'd1;
            state_s    = HOLD;
          end else begin
            state_s = LIGHTS;
          end
        end else begin
          state_s = LIGHTS;
        end
      end

      HOLD: begin
        if (react_re_s) begin
          false_start_s = 1'b1;
          tick_en_s     = 1'b0;
          data_s        = 8'h00;
          state_s       = FAULT;
        end else if (bus.tick) begin
          hold_cnt_s = hold_cnt_r - 8'd1;
          if (hold_cnt_r == 8'd1) begin
            data_s      = 8'h00;
            react_cnt_s = 16'h0000;
            tick_n_s    = N_REACT;
            state_s     = REACT;
          end else begin
            state_s = HOLD;
          end
        end else begin
          state_s = HOLD;
        end
      end

      REACT: begin
        if (react_re_s) begin
          react_time_s   = react_cnt_r;
          result_valid_s = 1'b1;
          tick_en_s      = 1'b0;
          state_s        = DONE;
        end else if (bus.tick && (react_cnt_r != REACT_SAT)) begin
          react_cnt_s = react_cnt_r + 16'd1;
        end else begin
          react_cnt_s = react_cnt_r;
        end
      end

      default: begin
        tick_en_s = 1'b0;
        data_s    = 8'h00;
        state_s   = IDLE;
      end
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r         <= 8'h00;
      tick_en_r      <= 1'b0;
      tick_n_r       <= N_LIGHT;
      react_time_r   <= 16'h0000;
      result_valid_r <= 1'b0;
      false_start_r  <= 1'b0;
      hold_cnt_r     <= 8'h00;
      react_cnt_r    <= 16'h0000;
    end else begin
      data_r         <= data_s;
      tick_en_r      <= tick_en_s;
      tick_n_r       <= tick_n_s;
      react_time_r   <= react_time_s;
      result_valid_r <= result_valid_s;
      false_start_r  <= false_start_s;
      hold_cnt_r     <= hold_cnt_s;
      react_cnt_r    <= react_cnt_s;
    end
  end

  assign bus.data_out     = data_r;
  assign bus.tick_en      = tick_en_r;
  assign bus.tick_n       = tick_n_r;
  assign bus.react_time   = react_time_r;
  assign bus.result_valid = result_valid_r;
  assign bus.false_start  = false_start_r;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Self-checking bench for f1_start_ctrl: directed scenarios plus a randomized
// loop, with expectations derived from the sequencer's rules (light pattern,
// LFSR-derived hold length, tick counts with saturation).
module tb_f1_start_ctrl;
  import f1_pkg::*;

  localparam logic [15:0] NL   = 16'd47999;
  localparam logic [15:0] NR   = 16'd47;
  localparam logic [7:0]  SEED = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b0;

  f1_start_ctrl_if bus();

  f1_start_ctrl #(.N_LIGHT(NL), .N_REACT(NR), .LFSR_SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rv_seen = 0;
  int rv_exp = 0;
  logic [15:0] last_rt = 16'h0000;
  logic [7:0]  m_lfsr;

  // Reference LFSR: the polynomial applied once per clock from the seed.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= SEED;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Count cycles in which result_valid is high.
  always @(negedge clk) begin
    if (bus.result_valid) rv_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap();
    cyc($urandom_range(0, 2));
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic start();
    bus.trigger = 1'b1;
    @(negedge clk);
    chk("start_ten",  32'(bus.tick_en), 32'd1);
    chk("start_tn",   32'(bus.tick_n), 32'(NL));
    chk("start_data", 32'(bus.data_out), 32'd0);
    chk("start_fs",   32'(bus.false_start), 32'd0);
    bus.trigger = 1'b0;
  endtask

  task automatic lights(input int upto);
    logic [8:0] v;
    for (int k = 1; k <= upto; k++) begin
      do_tick();
      v = (9'd1 << k) - 9'd1;
      chk("light_data", 32'(bus.data_out), 32'(v[7:0]));
      chk("light_tn",   32'(bus.tick_n), 32'(NL));
      gap();
    end
  endtask

  // Enter HOLD with the tick that finds all lights on, return the hold length.
  task automatic enter_hold(output int h);
    h = int'(m_lfsr & 8'h7F) + 1;
    do_tick();
    chk("hold_enter", 32'(bus.data_out), 32'hFF);
  endtask

  task automatic hold_phase();
    int h;
    enter_hold(h);
    for (int i = 1; i <= h; i++) begin
      gap();
      do_tick();
      if (i < h) begin
        chk("hold_on", 32'(bus.data_out), 32'hFF);
      end else begin
        chk("hold_out", 32'(bus.data_out), 32'd0);
        chk("hold_tn",  32'(bus.tick_n), 32'(NR));
        chk("hold_ten", 32'(bus.tick_en), 32'd1);
      end
    end
  endtask

  task automatic react_press(input logic [15:0] exp, input bit same);
    bus.react = 1'b1;
    bus.tick  = same;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("rv_pulse", 32'(bus.result_valid), 32'd1);
    chk("rt_value", 32'(bus.react_time), 32'(exp));
    chk("rt_ten",   32'(bus.tick_en), 32'd0);
    last_rt = exp;
    rv_exp++;
    @(negedge clk);
    chk("rv_single", 32'(bus.result_valid), 32'd0);
    bus.react = 1'b0;
    cyc(1);
  endtask

  task automatic react_phase(input int n, input bit same);
    for (int i = 0; i < n; i++) begin
      do_tick();
      gap();
    end
    react_press((n > 65535) ? 16'hFFFF : 16'(n), same);
  endtask

  task automatic false_press(input bit with_tick);
    bus.react = 1'b1;
    bus.tick  = with_tick;
    @(negedge clk);
    bus.tick = 1'b0;
    chk("fs_flag", 32'(bus.false_start), 32'd1);
    chk("fs_data", 32'(bus.data_out), 32'd0);
    chk("fs_ten",  32'(bus.tick_en), 32'd0);
    chk("fs_rv",   32'(bus.result_valid), 32'd0);
    chk("fs_rt",   32'(bus.react_time), 32'(last_rt));
    bus.react = 1'b0;
    cyc(1);
    do_tick();
    chk("fs_tick_ignored", 32'(bus.data_out), 32'd0);
  endtask

  initial begin
    int h;
    int j;
    bus.trigger = 1'b0;
    bus.react   = 1'b0;
    bus.tick    = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);

    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_ten",  32'(bus.tick_en), 32'd0);
    chk("rst_tn",   32'(bus.tick_n), 32'(NL));
    chk("rst_rt",   32'(bus.react_time), 32'd0);
    chk("rst_rv",   32'(bus.result_valid), 32'd0);
    chk("rst_fs",   32'(bus.false_start), 32'd0);
    do_tick();
    chk("idle_tick", 32'(bus.data_out), 32'd0);

    // Reset in the middle of the light sequence
    start();
    lights(3);
    rst = 1'b0;
    #1;
    chk("abort_data", 32'(bus.data_out), 32'd0);
    chk("abort_ten",  32'(bus.tick_en), 32'd0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    do_tick();
    chk("post_rst_data", 32'(bus.data_out), 32'd0);
    chk("post_rst_ten",  32'(bus.tick_en), 32'd0);

    // Full sequence with a mid-run trigger that must be ignored
    start();
    lights(5);
    bus.trigger = 1'b1;
    cyc(1);
    bus.trigger = 1'b0;
    chk("retrig_ignored", 32'(bus.data_out), 32'h1F);
    do_tick();
    do_tick();
    do_tick();
    chk("lights_full", 32'(bus.data_out), 32'hFF);
    hold_phase();
    react_phase(250, 1'b0);

    // Press and tick together at count 9
    start();
    lights(8);
    hold_phase();
    react_phase(9, 1'b1);

    // False start after three lights, then restart
    start();
    lights(3);
    false_press(1'b0);
    start();
    lights(8);
    hold_phase();
    react_phase(int'($urandom_range(0, 40)), 1'b0);

    // Randomized sequences
    for (int it = 0; it < 8; it++) begin
      start();
      case ($urandom_range(0, 3))
        0: begin
          lights(8);
          hold_phase();
          react_phase(int'($urandom_range(0, 300)), 1'b0);
        end
        1: begin
          lights(8);
          hold_phase();
          react_phase(int'($urandom_range(0, 300)), 1'b1);
        end
        2: begin
          lights(int'($urandom_range(0, 8)));
          false_press(1'($urandom_range(0, 1)));
        end
        default: begin
          lights(8);
          enter_hold(h);
          j = int'($urandom_range(0, h - 1));
          repeat (j) do_tick();
          false_press(1'($urandom_range(0, 1)));
        end
      endcase
    end

    // Saturation of the reaction counter
    start();
    lights(8);
    hold_phase();
    bus.tick = 1'b1;
    cyc(70000);
    bus.tick = 1'b0;
    react_press(16'hFFFF, 1'b0);

    cyc(3);
    chk("rv_count", 32'(rv_seen), 32'(rv_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
